uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter; the FPGA-to-BLE direction of the existing uart_rx link. Gameplay/debug logic pushes bytes into a small FIFO. The block serialises them onto ble_uart_rx at the same baud as uart_rx (BAUD_COUNT clocks per bit, clk_pixel domain), with start-of-frame gating by the BLE module's flow-control line.

---
 rtl/uart_tx_buffered.sv | 115 +++++++++++
 tb/tb_uart_tx_buffered.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART transmitter, frame starts gated by cts_in
// Ports: clk_in/rst_in clock and sync active-high reset; data_in/valid_in/ready_out enqueue handshake;
// cts_in clear-to-send; tx_out serial line (idle high); busy_out frame on line; count_out queued bytes.
module uart_tx_buffered #(
    parameter int BAUD_COUNT = 645,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          cts_in,
    output logic                          tx_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_COUNT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en, pop;

    state_t        state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shift, shift_d;
    logic          baud_done, can_start;

    // ready comes from the registered count, so a full FIFO rejects writes even while popping
    assign ready_out = count < DEPTH;
    assign wr_en     = valid_in && ready_out;
    assign count_out = count;
    assign baud_done = baud == BAUD_LAST;
    assign can_start = count != '0 && cts_in;
    assign busy_out  = state != IDLE;
    assign tx_out    = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;

    always_ff @(posedge clk_in)
        if (wr_en) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
        end
    end

    // The last STOP cycle may pop directly into a new START, giving gapless back-to-back frames
    always_comb begin
        state_d = state;
        baud_d  = baud + 1'b1;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: if (baud_done) begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (baud_done) begin
                baud_d  = '0;
                shift_d = shift >> 1;
                bit_d   = bit_idx + 1'b1;
                if (bit_idx == 3'd7) state_d = STOP;
            end
            STOP: if (baud_done) begin
                baud_d = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: cycle-accurate queue/frame-timeline reference model checked against uart_tx_buffered
module tb_uart_tx_buffered;
    localparam int B = 4;
    localparam int D = 8;
    localparam int FL = 10 * B;

    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] data = 0;
    logic       valid = 0;
    logic       cts = 0;
    logic       ready, tx, busy;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    bit         in_frame = 0;
    int         t = 0;
    logic [7:0] cur = 0;

    uart_tx_buffered #(.BAUD_COUNT(B), .FIFO_DEPTH(D)) dut (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid), .ready_out(ready),
        .cts_in(cts), .tx_out(tx), .busy_out(busy), .count_out(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level of a frame at time t: start 0, data LSB first, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int tt);
        int i = tt / B;
        return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
    endfunction

    task automatic model_edge();
        bit acc = valid && q.size() < D;
        if (rst) begin
            q.delete();
            in_frame = 0;
            t = 0;
            return;
        end
        if ((!in_frame || t == FL - 1) && q.size() > 0 && cts) begin
            cur = q.pop_front();
            in_frame = 1;
            t = 0;
        end else if (in_frame) begin
            if (t == FL - 1) in_frame = 0;
            else t++;
        end
        if (acc) q.push_back(data);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic r);
        valid = v;
        data = d;
        cts = c;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check("tx", 32'(tx), 32'(in_frame ? frame_bit(cur, t) : 1'b1));
        check("busy", 32'(busy), 32'(in_frame));
        check("count", 32'(count), q.size());
        check("ready", 32'(ready), 32'(q.size() < D));
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) cyc(0, 8'($urandom), c, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        idle(3, 1);
        cyc(1, 8'hA5, 1, 0);
        idle(50, 1);
        for (int i = 0; i < 9; i++) cyc(1, 8'(i), 0, 0);
        idle(10, 0);
        idle(8 * FL + 10, 1);
        cyc(1, 8'h3C, 0, 0);
        idle(30, 0);
        idle(1 + 4 * B, 1);
        idle(FL + 10, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 2 * FL + 5; i++) cyc(1, 8'($urandom), 1, 0);
        idle(9 * FL + 10, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h90 + i), 1, 0);
        idle(1 + 5 * B + 2, 1);
        cyc(0, 0, 1, 1);
        idle(FL + 10, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) != 0,
                $urandom_range(0, 999) == 0);
        idle(D * FL + FL, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
